// File: rtl/bsram_arbiter_if.sv
// Bundle of CPU, LCD and BSRAM port signals around the BSRAM arbiter.
// slave = arbiter view, master = surrounding requesters plus BSRAM primitive.
interface bsram_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              lcd_req;
   logic [ADDR_W-1:0] lcd_addr;
   logic              lcd_gnt;
   logic              lcd_rvalid;
   logic [DATA_W-1:0] lcd_rdata;
   logic              mem_ce;
   logic              mem_wre;
   logic [ADDR_W-1:0] mem_ad;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, lcd_req, lcd_addr, mem_dout,
      output cpu_gnt, cpu_rvalid, cpu_rdata, lcd_gnt, lcd_rvalid, lcd_rdata,
      output mem_ce, mem_wre, mem_ad, mem_din
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, lcd_req, lcd_addr, mem_dout,
      input  cpu_gnt, cpu_rvalid, cpu_rdata, lcd_gnt, lcd_rvalid, lcd_rdata,
      input  mem_ce, mem_wre, mem_ad, mem_din
   );
endinterface

// File: rtl/bsram_arbiter.sv
// Single-port BSRAM arbiter: LCD-over-CPU grant each cycle, read tags routed back after READ_LATENCY.
// Optional CPU anti-starvation counter enabled by `define BSRAM_ARB_STARVE_GUARD_EN.
module bsram_arbiter #(
   parameter int ADDR_W       = 13,
   parameter int DATA_W       = 8,
   parameter int READ_LATENCY = 1,
   parameter int STARVE_MAX   = 8
) (
   input  logic            clk,
   input  logic            rst,
   bsram_arbiter_if.slave  bus
);
   logic cpu_gnt;
   logic lcd_gnt;

`ifdef BSRAM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   logic [CNT_W-1:0] starve_q;
   logic [CNT_W-1:0] starve_d;
   logic             force_cpu;

   always_comb begin
      force_cpu = (starve_q == CNT_W'(STARVE_MAX));
      starve_d  = starve_q;
      if (!bus.cpu_req || cpu_gnt) begin
         starve_d = '0;
      end else if (!force_cpu) begin
         starve_d = starve_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   assign lcd_gnt = !rst && bus.lcd_req && !(force_cpu && bus.cpu_req);
`else
   assign lcd_gnt = !rst && bus.lcd_req;
`endif

   assign cpu_gnt = !rst && bus.cpu_req && !lcd_gnt;

   always_comb begin
      bus.cpu_gnt = cpu_gnt;
      bus.lcd_gnt = lcd_gnt;
      bus.mem_ce  = cpu_gnt || lcd_gnt;
      bus.mem_wre = cpu_gnt && bus.cpu_we;
      bus.mem_ad  = '0;
      bus.mem_din = '0;
      if (cpu_gnt) begin
         bus.mem_ad = bus.cpu_addr;
         if (bus.cpu_we) begin
            bus.mem_din = bus.cpu_wdata;
         end
      end else if (lcd_gnt) begin
         bus.mem_ad = bus.lcd_addr;
      end
   end

   // Tag shift register: owner bit 1 marks a CPU read, 0 an LCD read.
   logic [READ_LATENCY-1:0] vld_q;
   logic [READ_LATENCY-1:0] vld_d;
   logic [READ_LATENCY-1:0] own_q;
   logic [READ_LATENCY-1:0] own_d;

   always_comb begin
      vld_d    = '0;
      own_d    = '0;
      vld_d[0] = (cpu_gnt && !bus.cpu_we) || lcd_gnt;
      own_d[0] = cpu_gnt;
      for (int i = 1; i < READ_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         own_d[i] = own_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         own_q <= '0;
      end else begin
         vld_q <= vld_d;
         own_q <= own_d;
      end
   end

   logic tail_vld;
   assign tail_vld = vld_q[READ_LATENCY-1] && !rst;

   always_comb begin
      bus.cpu_rvalid = tail_vld && own_q[READ_LATENCY-1];
      bus.lcd_rvalid = tail_vld && !own_q[READ_LATENCY-1];
      bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_dout : '0;
      bus.lcd_rdata  = bus.lcd_rvalid ? bus.mem_dout : '0;
   end
endmodule

// File: doc/bsram_arbiter.md
Name: bsram_arbiter

Overview:
- Shares the single-port 8K x 8 BSRAM between two requesters: the CPU (read/write) and the LCD scanout reader (read-only).
- Arbitrates every clock, drives the BSRAM port, and tracks in-flight reads so each read returns to the requester that issued it.
- Sits between the cpu core, the LCD pixel fetch logic, and the BSRAM primitive.

Parameters:
- ADDR_W, 13, BSRAM address width
- DATA_W, 8, BSRAM data width
- READ_LATENCY, 1, cycles from an accepted read to valid mem_dout; legal values 1 or 2
- STARVE_MAX, 8, consecutive denied CPU cycles before a forced CPU grant; used only with the optional feature

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- lcd_req  in  1  LCD read request, held until granted
- lcd_addr  in  ADDR_W  LCD read address
- lcd_gnt  out  1  LCD read accepted this cycle
- lcd_rvalid  out  1  LCD read data valid
- lcd_rdata  out  DATA_W  LCD read data
- mem_ce  out  1  BSRAM clock enable
- mem_wre  out  1  BSRAM write enable
- mem_ad  out  ADDR_W  BSRAM address
- mem_din  out  DATA_W  BSRAM write data
- mem_dout  in  DATA_W  BSRAM read data

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. While rst=1:
  - gnt, mem_ce, mem_wre and rvalid outputs are forced to 0.
  - mem_ad, mem_din and rdata outputs are 0.
  - The tag pipeline and the starvation counter are cleared.
- Arbitration:
  - Combinational, at most one grant per cycle.
  - Default is fixed priority: LCD over CPU.
  - gnt may be asserted only in a cycle where the matching req=1.
- Port drive:
  - Granted cycle: mem_ce=1, mem_ad = granted address, mem_wre = cpu_we when CPU is granted, else 0; mem_din = cpu_wdata when CPU write, else 0.
  - No grant: mem_ce=0 and mem_wre=0.
- Tag pipeline:
  - READ_LATENCY-deep shift register of {valid, owner}.
  - Stage 0 loads valid=1 on a granted read (CPU read or LCD read).
  - Writes load valid=0.
- Return path:
  - Read response exactly READ_LATENCY cycles after the grant cycle: owner's rvalid=1 and owner's rdata=mem_dout.
  - Other requester: rvalid=0 and rdata=0.
  - Outputs are combinational from the pipeline tail and mem_dout.
- Throughput: back-to-back grants every cycle; responses return in grant order, one per cycle.
- CPU write: no response; a subsequent CPU read of the same address returns the new data.
- Simultaneous requests: LCD granted; CPU request stays pending; CPU is granted in the first cycle lcd_req=0.
- Requester contract: requester holds req, addr, we, wdata stable until gnt. A req dropped before gnt is treated as withdrawn; nothing is issued.
- Reset mid-operation: in-flight reads are discarded; no rvalid appears after rst, even if a grant preceded it.

Optional Feature:
- Macro: BSRAM_ARB_STARVE_GUARD_EN
- Defined: a counter of width $clog2(STARVE_MAX+1) behaves as follows:
  - Increments each cycle cpu_req=1 and cpu_gnt=0.
  - Clears on cpu_gnt or when cpu_req=0.
  - When it equals STARVE_MAX, the CPU wins the next contended cycle over the LCD.
- Not defined: strict LCD priority; no counter logic is present.

Test Plan:
- rst=1 for 2 cycles with cpu_req=lcd_req=1 -> cpu_gnt=lcd_gnt=0, mem_ce=0, both rvalid=0; after release, lcd_gnt=1 on the first non-reset cycle.
- CPU write addr 0x0200 data 0x06 -> same cycle: cpu_gnt=1, mem_ce=1, mem_wre=1, mem_ad=0x0200, mem_din=0x06; no rvalid follows. Next, CPU read 0x0200 -> cpu_rvalid=1 with cpu_rdata=0x06 exactly READ_LATENCY cycles later.
- lcd_req at 0x0100 and cpu_req read at 0x0200 in the same cycle N -> lcd_gnt at N, cpu_gnt at N+1; lcd_rvalid at N+1, cpu_rvalid at N+2 (READ_LATENCY=1), data matching preloaded memory.
- LCD reads 0x0000..0x0003 on consecutive cycles -> lcd_gnt every cycle, four consecutive lcd_rvalid pulses carrying mem contents in order; cpu_rvalid stays 0.
- CPU read granted at cycle N, rst=1 at N+1 -> no cpu_rvalid at any later cycle; mem_ce=0 during reset.
- Macro defined, STARVE_MAX=4, lcd_req and cpu_req both held high -> cpu_gnt on the 5th contended cycle, then LCD resumes. Macro undefined -> cpu_gnt never asserts while lcd_req=1.
